// File: rtl/layer_sequencer.sv
// Sequences one time-multiplexed neuron across every output of a fully connected
// layer: streams activation/weight pairs, supplies the bias, and stores each result.
module layer_sequencer #(
  parameter int IN_WIDTH    = 16,
  parameter int OUT_WIDTH   = 16,
  parameter int NUM_INPUTS  = 784,
  parameter int NUM_NEURONS = 10,
  parameter int ACT_AW      = 10,
  parameter int W_AW        = 13,
  parameter int N_AW        = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [ACT_AW-1:0]    act_addr,
  input  logic [IN_WIDTH-1:0]  act_rdata,
  output logic [W_AW-1:0]      w_addr,
  input  logic [IN_WIDTH-1:0]  w_rdata,
  output logic [N_AW-1:0]      b_addr,
  input  logic [IN_WIDTH-1:0]  b_rdata,
  output logic [IN_WIDTH-1:0]  neu_data,
  output logic [IN_WIDTH-1:0]  neu_weight,
  output logic [IN_WIDTH-1:0]  neu_bias,
  output logic                 neu_valid,
  input  logic [OUT_WIDTH-1:0] neu_out,
  input  logic                 neu_out_valid,
  output logic [N_AW-1:0]      res_addr,
  output logic [OUT_WIDTH-1:0] res_data,
  output logic                 res_we
);

  typedef enum logic [2:0] {
    S_IDLE, S_PRIME, S_STREAM, S_WAIT, S_WRITE, S_DONE
  } state_t;

  localparam logic [ACT_AW-1:0] LAST_IDX = ACT_AW'(NUM_INPUTS - 1);
  localparam logic [N_AW-1:0]   LAST_N   = N_AW'(NUM_NEURONS - 1);

  state_t                 state, state_next;
  logic                   issue;
  logic [OUT_WIDTH-1:0]   result;

  // issue marks a cycle whose address is a real read; neu_valid follows it by the
  // memory latency so data and valid line up at the neuron.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      act_addr  <= '0;
      w_addr    <= '0;
      b_addr    <= '0;
      issue     <= 1'b0;
      neu_valid <= 1'b0;
      result    <= '0;
    end else begin
      state     <= state_next;
      neu_valid <= issue;
      case (state)
        S_IDLE: begin
          if (start) begin
            act_addr <= '0;
            w_addr   <= '0;
            b_addr   <= '0;
            issue    <= 1'b1;
          end
        end
        S_PRIME, S_STREAM: begin
          if (issue) begin
            if (act_addr == LAST_IDX) begin
              issue <= 1'b0;
            end else begin
              act_addr <= act_addr + ACT_AW'(1);
              w_addr   <= w_addr + W_AW'(1);
            end
          end
        end
        S_WAIT: begin
          if (neu_out_valid) result <= neu_out;
        end
        S_WRITE: begin
          // The weight counter runs on from the previous neuron instead of multiplying.
          if (b_addr != LAST_N) begin
            b_addr   <= b_addr + N_AW'(1);
            act_addr <= '0;
            w_addr   <= w_addr + W_AW'(1);
            issue    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    busy       = (state != S_IDLE);
    done       = 1'b0;
    res_we     = 1'b0;
    case (state)
      S_IDLE:   if (start) state_next = S_PRIME;
      S_PRIME:  state_next = S_STREAM;
      S_STREAM: if (!issue) state_next = S_WAIT;
      S_WAIT:   if (neu_out_valid) state_next = S_WRITE;
      S_WRITE: begin
        res_we     = 1'b1;
        state_next = (b_addr == LAST_N) ? S_DONE : S_PRIME;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default:  state_next = S_IDLE;
    endcase
  end

  assign neu_data   = act_rdata;
  assign neu_weight = w_rdata;
  assign neu_bias   = b_rdata;
  assign res_addr   = b_addr;
  assign res_data   = result;

endmodule

// File: tb/tb_layer_sequencer.sv
// Randomized bench for layer_sequencer: memories and a neuron live here, and a
// cycle-position model predicts every output from the layer geometry alone.
module tb_layer_sequencer;

  localparam int N     = 4;
  localparam int NN    = 3;
  localparam int PER   = N + 3;
  localparam int TOTAL = NN * PER + 1;

  logic        clk = 1'b0;
  logic        rst, start;
  logic        busy, done, neu_valid, neu_out_valid, res_we;
  logic [9:0]  act_addr;
  logic [12:0] w_addr;
  logic [3:0]  b_addr, res_addr;
  logic [15:0] act_rdata, w_rdata, b_rdata;
  logic [15:0] neu_data, neu_weight, neu_bias, neu_out, res_data;

  logic [15:0] act_mem [N];
  logic [15:0] w_mem   [N*NN];
  logic [15:0] b_mem   [NN];
  logic [15:0] res_buf [NN];

  int  vectors = 0;
  int  miscompares = 0;
  int  k = 0;
  bit  clean = 1'b1;
  bit  checking = 1'b0;
  bit  noise_en = 1'b0;
  int  we_count = 0;
  int  mn, mp, lat;
  longint acc;
  int  cnt;

  layer_sequencer #(
    .IN_WIDTH(16), .OUT_WIDTH(16), .NUM_INPUTS(N), .NUM_NEURONS(NN),
    .ACT_AW(10), .W_AW(13), .N_AW(4)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .act_addr(act_addr), .act_rdata(act_rdata),
    .w_addr(w_addr), .w_rdata(w_rdata),
    .b_addr(b_addr), .b_rdata(b_rdata),
    .neu_data(neu_data), .neu_weight(neu_weight), .neu_bias(neu_bias),
    .neu_valid(neu_valid), .neu_out(neu_out), .neu_out_valid(neu_out_valid),
    .res_addr(res_addr), .res_data(res_data), .res_we(res_we)
  );

  always #5 clk = ~clk;

  // Neuron arithmetic: Q1.15 products summed in Q2.30, bias added, ReLU, Q8.8 saturate.
  function automatic logic [15:0] finish_q(longint sum);
    longint s = sum >>> 22;
    if (s < 0) return 16'h0000;
    if (s > 32767) return 16'h7FFF;
    return 16'(s);
  endfunction

  function automatic logic [15:0] model_result(int n);
    longint sum = longint'($signed(b_mem[n])) <<< 15;
    for (int i = 0; i < N; i++)
      sum += longint'($signed(act_mem[i])) * longint'($signed(w_mem[n*N+i]));
    return finish_q(sum);
  endfunction

  // Synchronous memories with one cycle of read latency.
  always @(posedge clk) begin
    act_rdata <= (act_addr < 10'(N))     ? act_mem[act_addr] : 16'h0;
    w_rdata   <= (w_addr   < 13'(N*NN))  ? w_mem[w_addr]     : 16'h0;
    b_rdata   <= (b_addr   < 4'(NN))     ? b_mem[b_addr]     : 16'h0;
  end

  // Bench neuron: answers one cycle after its Nth valid input, and otherwise
  // throws spurious out_valid pulses with junk data that must be ignored.
  always @(posedge clk) begin
    if (rst) begin
      acc <= 0; cnt <= 0; neu_out_valid <= 1'b0; neu_out <= 16'h0;
    end else if (neu_valid && cnt == N - 1) begin
      neu_out_valid <= 1'b1;
      neu_out <= finish_q(acc + longint'($signed(neu_data)) * longint'($signed(neu_weight))
                         + (longint'($signed(neu_bias)) <<< 15));
      acc <= 0; cnt <= 0;
    end else begin
      if (neu_valid) begin
        acc <= acc + longint'($signed(neu_data)) * longint'($signed(neu_weight));
        cnt <= cnt + 1;
      end
      neu_out_valid <= noise_en && ($urandom_range(0, 3) == 0);
      neu_out <= 16'($urandom);
    end
  end

  // Reference position within a run: k=1 is the cycle after the accepted start.
  always @(posedge clk) begin
    if (rst) begin
      k <= 0; clean <= 1'b1;
    end else if (k == 0) begin
      if (start) begin k <= 1; clean <= 1'b0; end
    end else if (k == TOTAL) begin
      k <= 0;
    end else begin
      k <= k + 1;
    end
  end

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      check_output("busy", 32'(busy), 32'(k != 0));
      check_output("done", 32'(done), 32'(k == TOTAL));
      if (k >= 1 && k < TOTAL) begin
        mn = (k - 1) / PER;
        mp = (k - 1) % PER;
        check_output("neu_valid", 32'(neu_valid), 32'(mp >= 1 && mp <= N));
        check_output("res_we", 32'(res_we), 32'(mp == N + 2));
        check_output("b_addr", 32'(b_addr), 32'(mn));
        if (mp < N) begin
          check_output("act_addr", 32'(act_addr), 32'(mp));
          check_output("w_addr", 32'(w_addr), 32'(mn * N + mp));
        end
        if (mp >= 1 && mp <= N) begin
          check_output("neu_data", 32'(neu_data), 32'(act_mem[mp-1]));
          check_output("neu_weight", 32'(neu_weight), 32'(w_mem[mn*N+mp-1]));
          check_output("neu_bias", 32'(neu_bias), 32'(b_mem[mn]));
        end
        if (mp == N + 2) begin
          check_output("res_addr", 32'(res_addr), 32'(mn));
          check_output("res_data", 32'(res_data), 32'(model_result(mn)));
        end
      end else begin
        check_output("idle_neu_valid", 32'(neu_valid), 32'h0);
        check_output("idle_res_we", 32'(res_we), 32'h0);
        if (clean) begin
          check_output("rst_act_addr", 32'(act_addr), 32'h0);
          check_output("rst_w_addr", 32'(w_addr), 32'h0);
          check_output("rst_b_addr", 32'(b_addr), 32'h0);
          check_output("rst_res_data", 32'(res_data), 32'h0);
        end
      end
    end
  end

  // Result buffer as the layer would see it.
  always @(negedge clk) begin
    if (res_we && res_addr < 4'(NN)) begin
      res_buf[res_addr] = res_data;
      we_count++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts a run from IDLE and returns the cycle (counting the start cycle as 0) in
  // which done was seen; extra re-pulses start while the run is in flight.
  task automatic apply_stimulus(input bit extra, output int latency);
    we_count = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    latency = -1;
    for (int c = 1; c <= 200; c++) begin
      if (done) begin
        latency = c;
        break;
      end
      start = extra && (c == 5 || c == 10);
      tick();
    end
    start = 1'b0;
    if (latency < 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL run_timeout: got no done, expected done at cycle %0d", TOTAL);
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < N; i++) act_mem[i] = 16'($urandom);
    for (int i = 0; i < N*NN; i++) w_mem[i] = 16'($urandom);
    for (int i = 0; i < NN; i++) b_mem[i] = 16'($urandom_range(0, 3) == 0 ? 0 : $urandom);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    for (int i = 0; i < N; i++) act_mem[i] = 16'h4000;
    for (int i = 0; i < N*NN; i++) w_mem[i] = 16'h4000;
    for (int i = 0; i < NN; i++) begin b_mem[i] = 16'h0; res_buf[i] = 16'hDEAD; end
    tick();
    checking = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    check_output("reset_busy", 32'(busy), 32'h0);
    check_output("reset_w_addr", 32'(w_addr), 32'h0);

    // 0.5 * 0.5 * 4 inputs = 1.0 -> 0x0100 in Q8.8 for every neuron.
    apply_stimulus(1'b0, lat);
    check_output("done_latency", 32'(lat), 32'd22);
    check_output("res_we_count", 32'(we_count), 32'd3);
    for (int i = 0; i < NN; i++) check_output("unit_result", 32'(res_buf[i]), 32'h0100);

    // A -1.0 bias cancels neuron 1 exactly.
    tick();
    b_mem[1] = 16'h8000;
    apply_stimulus(1'b0, lat);
    check_output("bias_res0", 32'(res_buf[0]), 32'h0100);
    check_output("bias_res1", 32'(res_buf[1]), 32'h0000);
    check_output("bias_res2", 32'(res_buf[2]), 32'h0100);

    // Extra starts mid-run are ignored; spurious neuron pulses start here.
    noise_en = 1'b1;
    tick();
    fill_random();
    apply_stimulus(1'b1, lat);
    check_output("extra_start_latency", 32'(lat), 32'd22);

    // Reset in the middle of neuron 1.
    tick();
    fill_random();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (8) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_output("midrst_busy", 32'(busy), 32'h0);
    check_output("midrst_neu_valid", 32'(neu_valid), 32'h0);
    check_output("midrst_act_addr", 32'(act_addr), 32'h0);
    check_output("midrst_w_addr", 32'(w_addr), 32'h0);
    tick();
    apply_stimulus(1'b0, lat);
    check_output("post_rst_latency", 32'(lat), 32'd22);
    check_output("post_rst_we_count", 32'(we_count), 32'd3);

    // Back-to-back: start held through DONE (ignored) and the following IDLE cycle.
    start = 1'b1;
    tick();
    apply_stimulus(1'b0, lat);
    check_output("b2b_latency", 32'(lat), 32'd22);
    check_output("b2b_we_count", 32'(we_count), 32'd3);

    for (int r = 0; r < 6; r++) begin
      tick();
      fill_random();
      repeat ($urandom_range(0, 3)) tick();
      apply_stimulus(1'($urandom_range(0, 1)), lat);
      check_output("rand_latency", 32'(lat), 32'd22);
    end

    repeat (3) tick();
    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/layer_sequencer.md
Name: layer_sequencer

Overview:
- Control stage wrapped around one `neuron` instance.
- Streams activation/weight pairs from synchronous memories into the neuron, supplies the per-neuron bias, captures each result and writes it to a result buffer.
- Time-multiplexes a single neuron across all NUM_NEURONS outputs of a fully connected layer (e.g. 784→10 MNIST layer).

Parameters:
- IN_WIDTH, 16, width of activations, weights and biases (Q1.15).
- OUT_WIDTH, 16, width of neuron result (Q8.8).
- NUM_INPUTS, 784, inputs per neuron; must equal the neuron's NUM_INPUTS.
- NUM_NEURONS, 10, neurons in the layer.
- ACT_AW, 10, activation address width (≥ clog2(NUM_INPUTS)).
- W_AW, 13, weight address width (≥ clog2(NUM_INPUTS*NUM_NEURONS)).
- N_AW, 4, neuron-index / bias / result address width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset; also drives the neuron's rst.
- start  in  1  one-cycle request to process the layer.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse after last result write.
- act_addr  out  ACT_AW  activation RAM read address.
- act_rdata  in  IN_WIDTH  activation data, 1-cycle read latency.
- w_addr  out  W_AW  weight ROM read address.
- w_rdata  in  IN_WIDTH  weight data, 1-cycle latency.
- b_addr  out  N_AW  bias ROM read address.
- b_rdata  in  IN_WIDTH  bias data, 1-cycle latency.
- neu_data  out  IN_WIDTH  to neuron data_in.
- neu_weight  out  IN_WIDTH  to neuron weight_in.
- neu_bias  out  IN_WIDTH  to neuron bias_in.
- neu_valid  out  1  to neuron input_valid.
- neu_out  in  OUT_WIDTH  neuron data_out.
- neu_out_valid  in  1  neuron out_valid.
- res_addr  out  N_AW  result buffer write address.
- res_data  out  OUT_WIDTH  result write data.
- res_we  out  1  result write enable, one cycle per neuron.

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0.
- Reset mid-operation returns to IDLE next edge with no res_we or done. Partial results already written stay in the buffer. The neuron's accumulator is cleared by the shared rst.
- FSM states:
  - IDLE → PRIME on start.
  - PRIME → STREAM.
  - STREAM → WAIT after last address issued and its data presented.
  - WAIT → WRITE on neu_out_valid.
  - WRITE → PRIME if neuron index < NUM_NEURONS-1, else DONE.
  - DONE → IDLE.
- start is ignored when not in IDLE.
- Address generation (all registered):
  - PRIME issues index i=0.
  - STREAM issues i=1..NUM_INPUTS-1 while presenting data for i-1.
  - act_addr = i.
  - w_addr = n*NUM_INPUTS + i, implemented as a running counter (no multiplier); it continues across neurons without reset.
  - b_addr = n, held for the whole neuron.
- Data path:
  - neu_data, neu_weight and neu_bias are direct passes of act_rdata, w_rdata and b_rdata.
  - neu_valid is the 1-cycle-delayed "address issued" flag.
  - neu_valid is high for exactly NUM_INPUTS consecutive cycles per neuron, never split, and low in WAIT, WRITE, PRIME, IDLE and DONE.
  - neu_bias is valid on every valid cycle, including the final one, where the neuron uses it.
- Result capture:
  - In WAIT, neu_out_valid (arrives 1 cycle after the last neu_valid) latches neu_out.
  - WRITE asserts res_we=1 for one cycle with res_addr=n and res_data=latched value.
  - neu_out_valid outside WAIT is ignored.
- Latency:
  - Per neuron: NUM_INPUTS+3 cycles (1 PRIME, NUM_INPUTS stream/valid cycles, 1 WAIT, 1 WRITE).
  - done is high NUM_NEURONS*(NUM_INPUTS+3)+1 cycles after the start edge.
  - busy falls together with done's deassertion, i.e. busy is high through the DONE cycle.
- Boundaries:
  - NUM_NEURONS=1: a single pass, then DONE.
  - Final neuron: no further PRIME; w_addr stops at NUM_INPUTS*NUM_NEURONS-1.
  - start asserted in the DONE cycle is ignored; start in the following IDLE cycle begins a new run from n=0, w_addr=0.

Test Plan:
- NUM_INPUTS=4, NUM_NEURONS=3, act=[0x4000×4], weights all 0x4000, biases 0 → each result equals the neuron model value. res_we pulses exactly 3 times with addresses 0,1,2. done arrives 22 cycles after start.
- Same config: check neu_valid is high in exactly 3 runs of 4 consecutive cycles each. Check w_addr sequence is 0..11 monotonic and b_addr equals n during each run.
- Bias on neuron 1 = 0x8000, others 0 → res_data[1]=0x0000 (ReLU), neurons 0 and 2 unaffected.
- Pulse start again at cycles 5 and 10 of a run → no restart. The trace is identical to the single-start run, with one done pulse.
- Assert rst at cycle 9 (mid neuron 1) → next cycle all outputs are 0 and the FSM is in IDLE. A subsequent start produces a correct full run from n=0.
- Back-to-back runs: start in the cycle after done → the second run is identical in timing and results to the first.
